adpcm_nibble_packer: RTL and testbench

Downstream stage of the `adpcm` codec in encode mode (`sel_rx=0`). It watches the codec's `ack` for rising edges and captures each 4-bit `tx_adpcm` code. It packs four codes into one 16-bit word, low nibble first in IMA order, and buffers the words in a small FIFO. A valid/ready stream carries the words to the storage or bus master.

---
 rtl/adpcm_pkg.sv | 20 ++
 rtl/adpcm_sync_fifo.sv | 73 +++++++
 rtl/adpcm_nibble_packer.sv | 116 +++++++++++
 tb/tb_adpcm_nibble_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// ============================================================================
// Module   : adpcm_pkg
// Brief    : Shared widths and types for the ADPCM codec and its packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adpcm_pkg;

    localparam int ADPCM_W       = 4;
    localparam int PCM_W         = 16;
    localparam int PACK_W        = 16;
    localparam int NIBS_PER_WORD = 4;

    typedef logic [ADPCM_W-1:0] adpcm_code_t;
    typedef logic [PACK_W-1:0]  adpcm_word_t;

endpackage : adpcm_pkg

`default_nettype wire

// File: rtl/adpcm_sync_fifo.sv
// ============================================================================
// Module   : adpcm_sync_fifo
// Brief    : Single-clock show-ahead FIFO with registered pointers and level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adpcm_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [LW-1:0]    o_level
);

    localparam int            c_pw      = $clog2(DEPTH);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
    localparam logic [LW-1:0] c_lvl_one = LW'(1);
    localparam logic [LW-1:0] c_lvl_max = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop & (r_level != '0);
    // A full FIFO still accepts when a pop frees the slot on the same edge.
    assign w_push_ok = i_push & ((r_level != c_lvl_max) | w_pop_ok);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_valid    = (r_level != '0);
    assign o_full     = (r_level == c_lvl_max);
    assign o_level    = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : adpcm_sync_fifo

`default_nettype wire

// File: rtl/adpcm_nibble_packer.sv
// ============================================================================
// Module   : adpcm_nibble_packer
// Brief    : Packs four ADPCM codes per 16-bit word into a valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adpcm_nibble_packer
    import adpcm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               ack,
    input  logic [ADPCM_W-1:0] tx_adpcm,
    input  logic               flush,
    input  logic               ovf_clr,
    output logic [PACK_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [LW-1:0]      level,
    output logic               ovf
);

    localparam int                 c_cnt_w    = $clog2(NIBS_PER_WORD);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NIBS_PER_WORD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_ack_q;
    logic [c_cnt_w-1:0] r_nib_cnt;
    adpcm_code_t        r_held [NIBS_PER_WORD-1];
    logic               r_ovf;

    logic               w_cap;
    logic [c_cnt_w:0]   w_fill;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    adpcm_word_t        w_word;

    // Tracks ack through reset so release never looks like a rising edge.
    always_ff @(posedge clk) begin
        r_ack_q <= ack;
    end

    assign w_cap  = enable & ack & ~r_ack_q;
    assign w_fill = {1'b0, r_nib_cnt} + {{c_cnt_w{1'b0}}, w_cap};
    assign w_push = enable & ((w_cap & (r_nib_cnt == c_cnt_last))
                            | (flush & (w_fill != '0)));
    assign w_pop  = m_valid & m_ready;

    // Held nibbles low-first, this cycle's capture at slot nib_cnt, rest zeroed.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NIBS_PER_WORD - 1; i++) begin
            w_word[i*ADPCM_W +: ADPCM_W] = r_held[i];
        end
        w_word[r_nib_cnt*ADPCM_W +: ADPCM_W] = tx_adpcm;
        for (int i = 0; i < NIBS_PER_WORD; i++) begin
            if ((c_cnt_w + 1)'(i) >= w_fill) begin
                w_word[i*ADPCM_W +: ADPCM_W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap && !w_push) begin
            r_held[r_nib_cnt] <= tx_adpcm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nib_cnt <= '0;
        end else if (!enable || w_push) begin
            r_nib_cnt <= '0;
        end else if (w_cap) begin
            r_nib_cnt <= r_nib_cnt + c_cnt_one;
        end
    end

    // A drop outranks a same-cycle clear so no overflow is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;

    adpcm_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PACK_W),
        .LW    (LW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_pop_data  (m_data),
        .o_valid     (m_valid),
        .o_full      (w_full),
        .o_level     (level)
    );

endmodule : adpcm_nibble_packer

`default_nettype wire

// File: tb/tb_adpcm_nibble_packer.sv
// ============================================================================
// Module   : tb_adpcm_nibble_packer
// Brief    : Directed self-checking bench for adpcm_nibble_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adpcm_nibble_packer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          ack;
    logic [3:0]    tx_adpcm;
    logic          flush;
    logic          ovf_clr;
    logic [15:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          ovf;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    adpcm_nibble_packer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .ack      (ack),
        .tx_adpcm (tx_adpcm),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One ack pulse: high for one cycle, low for one; returns on the
    // falling edge after the capture edge.
    task automatic send(input logic [3:0] code);
        @(negedge clk);
        ack      = 1'b1;
        tx_adpcm = code;
        @(negedge clk);
        ack      = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_words [4];

        rst      = 1'b1;
        enable   = 1'b1;
        ack      = 1'b1;
        tx_adpcm = 4'h0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
        m_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        ack = 1'b0;
        @(negedge clk);

        // Four codes, streamed out immediately
        send(4'h1);
        send(4'h2);
        send(4'h3);
        chk("w4321_pre_valid", 32'(m_valid), 32'd0);
        send(4'h4);
        chk("w4321_valid", 32'(m_valid), 32'd1);
        chk("w4321_data", 32'(m_data), 32'h4321);
        @(negedge clk);
        chk("w4321_one_cycle", 32'(m_valid), 32'd0);

        // Flush cases with the consumer stalled
        m_ready = 1'b0;
        send(4'hA);
        send(4'hB);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ab_level", 32'(level), 32'd1);
        chk("flush_ab_data", 32'(m_data), 32'h00BA);
        send(4'hA);
        send(4'hB);
        @(negedge clk);
        ack      = 1'b1;
        tx_adpcm = 4'hC;
        flush    = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        flush = 1'b0;
        chk("flush_cap_level", 32'(level), 32'd2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_empty_level", 32'(level), 32'd2);
        m_ready = 1'b1;
        chk("drain_00ba", 32'(m_data), 32'h00BA);
        @(negedge clk);
        chk("drain_0cba", 32'(m_data), 32'h0CBA);
        chk("drain_level1", 32'(level), 32'd1);
        @(negedge clk);
        chk("drain_empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // Overflow: 20 codes into a 4-word FIFO
        for (int i = 0; i < 20; i++) send(4'(i));
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_set", 32'(ovf), 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        exp_words[0] = 16'h3210;
        exp_words[1] = 16'h7654;
        exp_words[2] = 16'hBA98;
        exp_words[3] = 16'hFEDC;
        m_ready = 1'b1;
        chk("ovf_drain0", 32'(m_data), 32'(exp_words[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("ovf_drain", 32'(m_data), 32'(exp_words[k]));
        end
        @(negedge clk);
        chk("ovf_drain_empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // Full FIFO, pop on the same edge as the completing nibble
        for (int w = 1; w <= 4; w++) begin
            for (int n = 0; n < 4; n++) send(4'(w));
        end
        chk("full_level", 32'(level), 32'd4);
        send(4'h5);
        send(4'h5);
        send(4'h5);
        @(negedge clk);
        ack      = 1'b1;
        tx_adpcm = 4'h5;
        m_ready  = 1'b1;
        @(negedge clk);
        ack     = 1'b0;
        m_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(ovf), 32'd0);
        exp_words[0] = 16'h2222;
        exp_words[1] = 16'h3333;
        exp_words[2] = 16'h4444;
        exp_words[3] = 16'h5555;
        m_ready = 1'b1;
        chk("pp_drain0", 32'(m_data), 32'(exp_words[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("pp_drain", 32'(m_data), 32'(exp_words[k]));
        end
        @(negedge clk);
        chk("pp_drain_empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // Enable low discards the partial word
        send(4'h5);
        send(4'h6);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        send(4'h7);
        send(4'h8);
        send(4'h9);
        send(4'hA);
        chk("en_level", 32'(level), 32'd1);
        chk("en_data", 32'(m_data), 32'hA987);

        // Reset mid-word clears FIFO and partial word
        send(4'h1);
        send(4'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        send(4'h3);
        send(4'h4);
        send(4'h5);
        send(4'h6);
        chk("rst_after_level", 32'(level), 32'd1);
        chk("rst_after_data", 32'(m_data), 32'h6543);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_adpcm_nibble_packer

`default_nettype wire
